alu_scheduler: RTL and testbench

Round-robin scheduler that shares one saturating integer ALU (`ALU_Integer`: add/sub/mul, signed, N/V/Z flags) among `NUM_REQ` requesters such as SIMD lanes or issue ports. Each requester presents operands and opcode with a valid/ready handshake. The scheduler grants one requester at a time, registers its operands into the ALU, captures result and flags, and returns them on a per-requester valid/ready response channel. It sits between the issue stage and the execution datapath.

---
 rtl/alu_sched_pkg.sv | 18 +
 rtl/alu_scheduler_alu.sv | 52 +++++
 rtl/alu_scheduler.sv | 143 ++++++++++++++
 tb/tb_alu_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared types for the round-robin ALU scheduler:
// ALU opcodes and scheduler FSM states.
package alu_sched_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MUL  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/alu_scheduler_alu.sv
// Signed saturating integer ALU: add, sub, mul with N/V/Z flags.
// Purely combinational; the scheduler registers its inputs and outputs.
module ALU_Integer
    import alu_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic [1:0]            i_op,
    output logic [DATA_WIDTH-1:0] o_out,
    output logic                  o_n,
    output logic                  o_v,
    output logic                  o_z
);

    localparam int W = DATA_WIDTH;
    localparam logic signed [2*W-1:0] MAXV = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W-1:0] MINV = {{(W+1){1'b1}}, {(W-1){1'b0}}};

    logic signed [2*W-1:0] w_ax;
    logic signed [2*W-1:0] w_bx;
    logic signed [2*W-1:0] w_wide;

    // Double-width operands hold any exact sum, difference or product
    assign w_ax = {{W{i_a[W-1]}}, i_a};
    assign w_bx = {{W{i_b[W-1]}}, i_b};

    always_comb begin
        w_wide = '0;
        o_out  = '0;
        o_v    = 1'b0;
        case (op_e'(i_op))
            OP_ADD:  w_wide = w_ax + w_bx;
            OP_SUB:  w_wide = w_ax - w_bx;
            OP_MUL:  w_wide = w_ax * w_bx;
            default: w_wide = '0;
        endcase
        if (w_wide > MAXV) begin
            o_out = MAXV[W-1:0];
            o_v   = 1'b1;
        end else if (w_wide < MINV) begin
            o_out = MINV[W-1:0];
            o_v   = 1'b1;
        end else begin
            o_out = w_wide[W-1:0];
        end
        o_n = o_out[W-1];
        o_z = (o_out == '0);
    end

endmodule

// File: rtl/alu_scheduler.sv
// Round-robin arbiter sharing one saturating ALU among NUM_REQ
// requesters, with one outstanding operation and a per-requester response.
module alu_scheduler
    import alu_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_b,
    input  logic [NUM_REQ*2-1:0]          i_req_op,
    output logic [NUM_REQ-1:0]            o_rsp_valid,
    input  logic [NUM_REQ-1:0]            i_rsp_ready,
    output logic [DATA_WIDTH-1:0]         o_rsp_data,
    output logic                          o_rsp_n,
    output logic                          o_rsp_v,
    output logic                          o_rsp_z,
    output logic                          o_rsp_err,
    output logic                          o_busy
);

    localparam int IW = $clog2(NUM_REQ);

    state_e                r_state;
    state_e                w_next;
    logic [IW-1:0]         r_rr_ptr;
    logic [IW-1:0]         r_gnt;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    op_e                   r_op;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_n;
    logic                  r_v;
    logic                  r_z;
    logic                  r_err;

    logic [IW-1:0]         w_gnt;
    logic [IW:0]           w_idx;
    logic                  w_any;
    logic                  w_req_hs;
    logic [IW-1:0]         w_ptr_nxt;
    logic [DATA_WIDTH-1:0] w_alu_out;
    logic                  w_alu_n;
    logic                  w_alu_v;
    logic                  w_alu_z;

    // Walk downward so the requester closest to r_rr_ptr wins last
    always_comb begin
        w_gnt = r_rr_ptr;
        w_any = 1'b0;
        w_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_rr_ptr} + (IW+1)'(k);
            if (w_idx >= (IW+1)'(NUM_REQ)) begin
                w_idx = w_idx - (IW+1)'(NUM_REQ);
            end
            if (i_req_valid[w_idx[IW-1:0]]) begin
                w_gnt = w_idx[IW-1:0];
                w_any = 1'b1;
            end
        end
    end

    assign w_req_hs  = (r_state == ST_IDLE) && w_any && !i_rst;
    assign w_ptr_nxt = (w_gnt == IW'(NUM_REQ - 1)) ? '0 : w_gnt + IW'(1);

    assign o_req_ready = w_req_hs ? (NUM_REQ'(1) << w_gnt) : '0;
    assign o_rsp_valid = (r_state == ST_RESP) ? (NUM_REQ'(1) << r_gnt) : '0;
    assign o_rsp_data  = r_data;
    assign o_rsp_n     = r_n;
    assign o_rsp_v     = r_v;
    assign o_rsp_z     = r_z;
    assign o_rsp_err   = r_err;
    assign o_busy      = (r_state != ST_IDLE);

    ALU_Integer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .i_a   (r_a),
        .i_b   (r_b),
        .i_op  (r_op),
        .o_out (w_alu_out),
        .o_n   (w_alu_n),
        .o_v   (w_alu_v),
        .o_z   (w_alu_z)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_req_hs) w_next = ST_EXEC;
            ST_EXEC: w_next = ST_RESP;
            ST_RESP: if (i_rsp_ready[r_gnt]) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_gnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= OP_ADD;
            r_data   <= '0;
            r_n      <= 1'b0;
            r_v      <= 1'b0;
            r_z      <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_req_hs) begin
                r_gnt    <= w_gnt;
                r_rr_ptr <= w_ptr_nxt;
                r_a      <= i_req_a[w_gnt*DATA_WIDTH +: DATA_WIDTH];
                r_b      <= i_req_b[w_gnt*DATA_WIDTH +: DATA_WIDTH];
                r_op     <= op_e'(i_req_op[w_gnt*2 +: 2]);
            end
            if (r_state == ST_EXEC) begin
                // Reserved opcode: flag an error and report all-zero result
                if (r_op == OP_RSVD) begin
                    r_data <= '0;
                    r_n    <= 1'b0;
                    r_v    <= 1'b0;
                    r_z    <= 1'b0;
                    r_err  <= 1'b1;
                end else begin
                    r_data <= w_alu_out;
                    r_n    <= w_alu_n;
                    r_v    <= w_alu_v;
                    r_z    <= w_alu_z;
                    r_err  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed self-checking bench for alu_scheduler (DATA_WIDTH 8, NUM_REQ 4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_alu_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [7:0]  req_op;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_ready;
    logic [7:0]  rsp_data;
    logic        rsp_n;
    logic        rsp_v;
    logic        rsp_z;
    logic        rsp_err;
    logic        busy;

    int n_checks;
    int n_errors;

    alu_scheduler #(
        .DATA_WIDTH (8),
        .NUM_REQ    (4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .i_req_op    (req_op),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
        .o_rsp_n     (rsp_n),
        .o_rsp_v     (rsp_v),
        .o_rsp_z     (rsp_z),
        .o_rsp_err   (rsp_err),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_req(input int i, input logic [7:0] a,
                           input logic [7:0] b, input logic [1:0] op);
        req_a[i*8 +: 8]  = a;
        req_b[i*8 +: 8]  = b;
        req_op[i*2 +: 2] = op;
        req_valid[i]     = 1'b1;
    endtask

    // Called on a falling edge in IDLE; returns on the falling edge of EXEC
    task automatic issue(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op, output logic [3:0] rdy);
        set_req(i, a, b, op);
        #1 rdy = req_ready;
        @(posedge clk);
        @(negedge clk);
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (rsp_valid == 4'b0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic ack();
        rsp_ready = 4'hF;
        @(negedge clk);
        rsp_ready = 4'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 4'b0 || rsp_valid !== 4'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_hs: ready=%b valid=%b busy=%b want 0000 0000 0",
                     req_ready, rsp_valid, busy);
        end
        n_checks++;
        if ({rsp_data, rsp_n, rsp_v, rsp_z, rsp_err} !== 12'h0) begin
            n_errors++;
            $display("FAIL reset_rsp: data=%h nvze=%b%b%b%b want 00 0000",
                     rsp_data, rsp_n, rsp_v, rsp_z, rsp_err);
        end
    endtask

    task automatic test_single_add();
        logic [3:0] rdy;
        int cyc;
        @(negedge clk);
        issue(0, 8'h01, 8'h01, 2'b00, rdy);
        n_checks++;
        if (rdy !== 4'b0001) begin
            n_errors++;
            $display("FAIL add_ready: got %b want 0001", rdy);
        end
        n_checks++;
        if (busy !== 1'b1 || rsp_valid !== 4'b0) begin
            n_errors++;
            $display("FAIL add_exec: busy=%b valid=%b want 1 0000", busy, rsp_valid);
        end
        wait_rsp(cyc);
        n_checks++;
        if (cyc !== 1 || rsp_valid !== 4'b0001) begin
            n_errors++;
            $display("FAIL add_latency: cyc=%0d valid=%b want 1 0001", cyc, rsp_valid);
        end
        n_checks++;
        if ({rsp_data, rsp_n, rsp_v, rsp_z, rsp_err} !== {8'h02, 4'b0000}) begin
            n_errors++;
            $display("FAIL add_result: data=%h nvze=%b%b%b%b want 02 0000",
                     rsp_data, rsp_n, rsp_v, rsp_z, rsp_err);
        end
        ack();
        n_checks++;
        if (rsp_valid !== 4'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL add_done: valid=%b busy=%b want 0000 0", rsp_valid, busy);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] rdy;
        int cyc;
        issue(2, 8'h7F, 8'h01, 2'b00, rdy);
        wait_rsp(cyc);
        n_checks++;
        if (rdy !== 4'b0100 || rsp_valid !== 4'b0100) begin
            n_errors++;
            $display("FAIL sat_add_hs: rdy=%b valid=%b want 0100 0100", rdy, rsp_valid);
        end
        n_checks++;
        if ({rsp_data, rsp_n, rsp_v, rsp_z} !== {8'h7F, 3'b010}) begin
            n_errors++;
            $display("FAIL sat_add: data=%h nvz=%b%b%b want 7f 010",
                     rsp_data, rsp_n, rsp_v, rsp_z);
        end
        ack();
        issue(3, 8'hC0, 8'h0A, 2'b10, rdy);
        wait_rsp(cyc);
        n_checks++;
        if (rdy !== 4'b1000 || rsp_valid !== 4'b1000) begin
            n_errors++;
            $display("FAIL sat_mul_hs: rdy=%b valid=%b want 1000 1000", rdy, rsp_valid);
        end
        n_checks++;
        if ({rsp_data, rsp_n, rsp_v, rsp_z} !== {8'h80, 3'b110}) begin
            n_errors++;
            $display("FAIL sat_mul: data=%h nvz=%b%b%b want 80 110",
                     rsp_data, rsp_n, rsp_v, rsp_z);
        end
        ack();
    endtask

    task automatic test_reserved();
        logic [3:0] rdy;
        int cyc;
        issue(0, 8'h05, 8'h02, 2'b11, rdy);
        wait_rsp(cyc);
        n_checks++;
        if ({rsp_valid, rsp_data, rsp_n, rsp_v, rsp_z, rsp_err} !==
            {4'b0001, 8'h00, 4'b0001}) begin
            n_errors++;
            $display("FAIL rsvd: valid=%b data=%h nvze=%b%b%b%b want 0001 00 0001",
                     rsp_valid, rsp_data, rsp_n, rsp_v, rsp_z, rsp_err);
        end
        ack();
        issue(1, 8'h03, 8'h04, 2'b00, rdy);
        wait_rsp(cyc);
        n_checks++;
        if ({rsp_valid, rsp_data, rsp_err} !== {4'b0010, 8'h07, 1'b0}) begin
            n_errors++;
            $display("FAIL rsvd_after: valid=%b data=%h err=%b want 0010 07 0",
                     rsp_valid, rsp_data, rsp_err);
        end
        ack();
    endtask

    task automatic test_backpressure();
        logic [3:0] rdy;
        int cyc;
        issue(1, 8'h04, 8'h04, 2'b01, rdy);
        set_req(3, 8'h10, 8'h20, 2'b00);
        rsp_ready = 4'b1001;
        wait_rsp(cyc);
        n_checks++;
        if (rdy !== 4'b0010 || rsp_valid !== 4'b0010) begin
            n_errors++;
            $display("FAIL bp_grant: rdy=%b valid=%b want 0010 0010", rdy, rsp_valid);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if ({rsp_valid, rsp_data, rsp_z, busy, req_ready} !==
                {4'b0010, 8'h00, 1'b1, 1'b1, 4'b0000}) begin
                n_errors++;
                $display("FAIL bp_hold%0d: valid=%b data=%h z=%b busy=%b ready=%b",
                         c, rsp_valid, rsp_data, rsp_z, busy, req_ready);
            end
        end
        rsp_ready = 4'b0010;
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_errors++;
            $display("FAIL bp_release_same: ready=%b want 0000", req_ready);
        end
        @(negedge clk);
        rsp_ready = 4'b0000;
        #1;
        n_checks++;
        if (req_ready !== 4'b1000 || rsp_valid !== 4'b0000) begin
            n_errors++;
            $display("FAIL bp_next_grant: ready=%b valid=%b want 1000 0000",
                     req_ready, rsp_valid);
        end
        @(negedge clk);
        req_valid[3] = 1'b0;
        wait_rsp(cyc);
        n_checks++;
        if (rsp_valid !== 4'b1000 || rsp_data !== 8'h30) begin
            n_errors++;
            $display("FAIL bp_req3: valid=%b data=%h want 1000 30", rsp_valid, rsp_data);
        end
        ack();
    endtask

    task automatic test_round_robin();
        int cyc;
        logic [3:0] exp;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 8'(i + 1), 8'h10, 2'b00);
        @(negedge clk);
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_errors++;
            $display("FAIL rr_in_reset: ready=%b want 0000", req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            exp = 4'b0001 << (n % 4);
            cyc = 0;
            #1;
            while (req_ready == 4'b0 && cyc < 10) begin
                @(negedge clk);
                #1;
                cyc++;
            end
            n_checks++;
            if (req_ready !== exp) begin
                n_errors++;
                $display("FAIL rr_grant%0d: ready=%b want %b", n, req_ready, exp);
            end
            @(negedge clk);
            wait_rsp(cyc);
            n_checks++;
            if (rsp_valid !== exp || rsp_data !== 8'(8'h11 + n % 4)) begin
                n_errors++;
                $display("FAIL rr_rsp%0d: valid=%b data=%h want %b %h",
                         n, rsp_valid, rsp_data, exp, 8'(8'h11 + n % 4));
            end
            ack();
        end
        req_valid = 4'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        logic [3:0] rdy;
        int cyc;
        issue(2, 8'h03, 8'h05, 2'b01, rdy);
        n_checks++;
        if (rdy !== 4'b0100 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_grant: rdy=%b busy=%b want 0100 1", rdy, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 4'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset: valid=%b busy=%b want 0000 0", rsp_valid, busy);
        end
        rst = 1'b0;
        set_req(3, 8'h01, 8'h01, 2'b00);
        issue(2, 8'h03, 8'h05, 2'b01, rdy);
        req_valid[3] = 1'b0;
        n_checks++;
        if (rdy !== 4'b0100) begin
            n_errors++;
            $display("FAIL mid_ptr: rdy=%b want 0100", rdy);
        end
        wait_rsp(cyc);
        n_checks++;
        if ({rsp_valid, rsp_data, rsp_n, rsp_v, rsp_z} !== {4'b0100, 8'hFE, 3'b100}) begin
            n_errors++;
            $display("FAIL mid_reissue: valid=%b data=%h nvz=%b%b%b want 0100 fe 100",
                     rsp_valid, rsp_data, rsp_n, rsp_v, rsp_z);
        end
        ack();
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = '0;
        test_reset();
        test_single_add();
        test_saturation();
        test_reserved();
        test_backpressure();
        test_round_robin();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
